// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (double dabble), one
// operand bit per clock, MSB first. The result is three BCD digits, which
// covers every operand up to 9 bits wide.
//
// Optional build macro:
//   BCD_SERIAL_EN - adds dig_out/dig_valid, which replay the finished result
//                   one digit at a time: hundreds, tens, ones.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous reset, active high
//   start     in   convert bin_in; only looked at while busy=0
//   bin_in    in   unsigned operand, BIN_W bits
//   busy      out  conversion (and digit stream) in progress
//   done      out  one-cycle pulse when bcd_* take a new value
//   bcd_hund  out  hundreds digit
//   bcd_tens  out  tens digit
//   bcd_ones  out  ones digit
//   dig_out   out  serial digit                  (BCD_SERIAL_EN only)
//   dig_valid out  dig_out qualifier             (BCD_SERIAL_EN only)
//
// state  | meaning
// S_IDLE   | waiting for start; bcd_* hold the last result
// S_SHIFT  | one add-3/shift step per clock, BIN_W steps in total
// S_STREAM | hundreds and tens digits on dig_out (BCD_SERIAL_EN only)

module bin_to_bcd_seq #(
  parameter int BIN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bcd_hund,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones
`ifdef BCD_SERIAL_EN
  ,
  output logic [3:0]       dig_out,
  output logic             dig_valid
`endif
);

  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT
`ifdef BCD_SERIAL_EN
    ,
    S_STREAM
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   opnd_q, opnd_d;
  logic [11:0]        scr_q, scr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         hund_q, hund_d;
  logic [3:0]         tens_q, tens_d;
  logic [3:0]         ones_q, ones_d;
  logic               done_q, done_d;
`ifdef BCD_SERIAL_EN
  logic [3:0]         dig_q, dig_d;
  logic               dval_q, dval_d;
  logic               sidx_q, sidx_d;
`endif

  logic [11:0]        adj;
  logic [11:0]        shifted;

  function automatic logic [3:0] add3(input logic [3:0] dig);
    add3 = (dig >= 4'd5) ? dig + 4'd3 : dig;
  endfunction

  always_comb begin
    adj     = {add3(scr_q[11:8]), add3(scr_q[7:4]), add3(scr_q[3:0])};
    // Operand is consumed from its MSB; the hundreds digit never overflows
    // for BIN_W <= 9, so dropping the top bit of the shift loses nothing.
    shifted = (adj << 1) | {11'd0, opnd_q[BIN_W-1]};
  end

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    done_d  = 1'b0;
`ifdef BCD_SERIAL_EN
    dig_d   = dig_q;
    dval_d  = 1'b0;
    sidx_d  = sidx_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          opnd_d  = bin_in;
          scr_d   = '0;
          cnt_d   = CNT_W'(BIN_W - 1);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        scr_d  = shifted;
        opnd_d = opnd_q << 1;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          hund_d  = shifted[11:8];
          tens_d  = shifted[7:4];
          ones_d  = shifted[3:0];
          done_d  = 1'b1;
`ifdef BCD_SERIAL_EN
          dig_d   = shifted[11:8];
          dval_d  = 1'b1;
          sidx_d  = 1'b0;
          state_d = S_STREAM;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef BCD_SERIAL_EN
      S_STREAM: begin
        dval_d = 1'b1;
        if (!sidx_q) begin
          dig_d  = tens_q;
          sidx_d = 1'b1;
        end else begin
          // Ones digit is presented from IDLE so busy drops with it.
          dig_d   = ones_q;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      opnd_q  <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      hund_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      done_q  <= 1'b0;
`ifdef BCD_SERIAL_EN
      dig_q   <= '0;
      dval_q  <= 1'b0;
      sidx_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      done_q  <= done_d;
`ifdef BCD_SERIAL_EN
      dig_q   <= dig_d;
      dval_q  <= dval_d;
      sidx_q  <= sidx_d;
`endif
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign bcd_hund = hund_q;
  assign bcd_tens = tens_q;
  assign bcd_ones = ones_q;
`ifdef BCD_SERIAL_EN
  assign dig_out   = dig_q;
  assign dig_valid = dval_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  localparam int BIN_W = 8;
`ifdef BCD_SERIAL_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  typedef logic [BIN_W-1:0] bin_t;
  typedef struct {int due; int h; int t; int o;} res_t;
  typedef struct {int due; int d;} dig_t;

  logic       clk;
  logic       rst;
  logic       start;
  bin_t       bin_in;
  logic       busy;
  logic       done;
  logic [3:0] bcd_hund;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
`ifdef BCD_SERIAL_EN
  logic [3:0] dig_out;
  logic       dig_valid;
`endif

  bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_hund (bcd_hund),
    .bcd_tens (bcd_tens),
    .bcd_ones (bcd_ones)
`ifdef BCD_SERIAL_EN
    ,
    .dig_out  (dig_out),
    .dig_valid(dig_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, advanced by the driver at each rising edge.
  int   edge_n   = 0;
  int   busy_end = -1000;
  int   rst_edge = -1;
  res_t sb[$];
  dig_t dq[$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
    end
  endfunction

  task automatic step(input logic r, input logic s, input bin_t b);
    res_t e;
    @(negedge clk);
    rst    = r;
    start  = s;
    bin_in = b;
    @(posedge clk);
    edge_n++;
    if (r) begin
      sb.delete();
      dq.delete();
      busy_end = edge_n;
      rst_edge = edge_n;
    end else if (s && edge_n > busy_end) begin
      e.due = edge_n + BIN_W;
      e.h   = int'(b) / 100;
      e.t   = (int'(b) / 10) % 10;
      e.o   = int'(b) % 10;
      sb.push_back(e);
      dq.push_back('{e.due,     e.h});
      dq.push_back('{e.due + 1, e.t});
      dq.push_back('{e.due + 2, e.o});
      busy_end = edge_n + BIN_W + EXTRA;
    end
  endtask

  task automatic convert(input bin_t v);
    int guard;
    guard = 0;
    while (edge_n + 1 <= busy_end && guard < 40) begin
      step(1'b0, 1'b0, bin_t'($urandom));
      guard++;
    end
    step(1'b0, 1'b1, v);
  endtask

  // Monitor: compares every cycle against the model, popping results when due.
  int exp_h = 0, exp_t = 0, exp_o = 0;
  always @(negedge clk) begin
    int due_now;
    if (edge_n > 0) begin
      due_now = 0;
      if (rst_edge == edge_n) begin
        exp_h = 0; exp_t = 0; exp_o = 0;
`ifdef BCD_SERIAL_EN
        chk("dig_out_reset", int'(dig_out), 0);
`endif
      end
      if (sb.size() > 0 && sb[0].due == edge_n) begin
        due_now = 1;
        exp_h = sb[0].h; exp_t = sb[0].t; exp_o = sb[0].o;
        void'(sb.pop_front());
      end
      chk("done", int'(done), due_now);
      chk("busy", int'(busy), (edge_n < busy_end) ? 1 : 0);
      chk("bcd_hund", int'(bcd_hund), exp_h);
      chk("bcd_tens", int'(bcd_tens), exp_t);
      chk("bcd_ones", int'(bcd_ones), exp_o);
`ifdef BCD_SERIAL_EN
      if (dq.size() > 0 && dq[0].due == edge_n) begin
        chk("dig_valid", int'(dig_valid), 1);
        chk("dig_out", int'(dig_out), dq[0].d);
        void'(dq.pop_front());
      end else begin
        chk("dig_valid_idle", int'(dig_valid), 0);
      end
`else
      dq.delete();
`endif
    end
  end

  initial begin
    int guard;
    rst = 1'b1; start = 1'b0; bin_in = '0;
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, bin_t'(5));   // start together with reset is dropped
    step(1'b0, 1'b1, bin_t'(7));   // first edge after reset accepts
    convert(bin_t'(0));
    convert(bin_t'(255));
    convert(bin_t'(99));
    convert(bin_t'(9));
    convert(bin_t'(137));

    for (int v = 0; v < (1 << BIN_W); v++) convert(bin_t'(v));

    // Back-to-back: start held high, operand incrementing every cycle.
    for (int i = 0; i < 60; i++) step(1'b0, 1'b1, bin_t'(i));

    // Extra start and operand churn during SHIFT are ignored.
    convert(bin_t'(200));
    for (int k = 1; k < BIN_W; k++)
      step(1'b0, 1'b1, (k == 1) ? bin_t'(17) : bin_t'($urandom));
    step(1'b0, 1'b0, bin_t'($urandom));

    // Reset on the 4th SHIFT edge aborts the conversion.
    convert(bin_t'(123));
    for (int k = 1; k < 4; k++) step(1'b0, 1'b0, bin_t'($urandom));
    step(1'b1, 1'b0, bin_t'($urandom));
    convert(bin_t'(42));

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1), bin_t'($urandom));

    guard = 0;
    while ((sb.size() > 0 || dq.size() > 0 || edge_n <= busy_end + 2) && guard < 60) begin
      step(1'b0, 1'b0, bin_t'($urandom));
      guard++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d results still outstanding, expected 0", sb.size());
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
